// File: rtl/pulse_stretch_pkg.sv
// Shared types and default timing for the pulse stretcher.
// Default durations match the N=21 timing used by the debounce path.
package pulse_stretch_pkg;

  localparam int DEF_N       = 21;
  localparam int DEF_ON_CNT  = 2097151;
  localparam int DEF_OFF_CNT = 2097151;
  localparam int DEF_PEND_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    GAP  = 2'b10
  } state_t;

endpackage

// File: rtl/pulse_stretch_load_down_counter.sv
// Loadable down-counter that holds at zero instead of wrapping.
// The load input takes priority over the decrement.
module load_down_counter #(
  parameter int N = 21
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [N-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [N-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Turns single-cycle ticks into ON_CNT-cycle high pulses, each followed by an
// OFF_CNT-cycle low gap; ticks arriving while busy are queued, not merged.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int ON_CNT  = DEF_ON_CNT,
  parameter int OFF_CNT = DEF_OFF_CNT,
  parameter int PEND_W  = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              clr_ovf,
  output logic              level,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf,
  output state_t            dbg_state
);

  localparam logic [N-1:0]      ON_LOAD  = N'(ON_CNT - 1);
  localparam logic [N-1:0]      OFF_LOAD = N'(OFF_CNT - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            r_state;
  logic              r_level;
  logic              r_busy;
  logic [PEND_W-1:0] r_pend;
  logic              r_ovf;

  logic              w_zero;
  logic              w_load;
  logic [N-1:0]      w_load_val;
  logic              w_en;
  logic              w_gap_end;
  logic              w_consume_q;
  logic              w_tick_direct;
  logic              w_tick_queue;
  logic              w_drop;
  logic              w_inc;
  logic [PEND_W-1:0] w_pend_next;

  // A tick starts a pulse directly in IDLE, or at the GAP end with nothing
  // queued; every other tick goes through the pending counter.
  always_comb begin
    w_gap_end     = (r_state == GAP) && w_zero;
    w_consume_q   = w_gap_end && (r_pend != '0);
    w_tick_direct = tick && ((r_state == IDLE) || (w_gap_end && (r_pend == '0)));
    w_tick_queue  = tick && !w_tick_direct;
    w_drop        = w_tick_queue && (r_pend == PEND_MAX) && !w_consume_q;
    w_inc         = w_tick_queue && !w_drop;

    w_pend_next = r_pend;
    if (w_inc && !w_consume_q) begin
      w_pend_next = r_pend + 1'b1;
    end else if (!w_inc && w_consume_q) begin
      w_pend_next = r_pend - 1'b1;
    end

    w_load = ((r_state == IDLE) && tick) ||
             ((r_state == ON) && w_zero) ||
             (w_gap_end && ((r_pend != '0) || tick));
    w_load_val = (r_state == ON) ? OFF_LOAD : ON_LOAD;
    w_en       = (r_state != IDLE);
  end

  load_down_counter #(.N(N)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tick) begin
            r_state <= ON;
            r_level <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ON: begin
          if (w_zero) begin
            r_state <= GAP;
            r_level <= 1'b0;
          end
        end
        GAP: begin
          if (w_zero) begin
            if ((r_pend != '0) || tick) begin
              r_state <= ON;
              r_level <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_level <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase

      r_pend <= w_pend_next;

      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign level     = r_level;
  assign busy      = r_busy;
  assign pend_cnt  = r_pend;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with ON_CNT=4, OFF_CNT=3, PEND_W=2.
// Cycle k is the interval after clock edge k counted from reset release.
module tb_pulse_stretch;
  import pulse_stretch_pkg::*;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       clr_ovf;
  logic       level;
  logic       busy;
  logic [1:0] pend_cnt;
  logic       ovf;
  state_t     dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rises  = 0;
  logic prev_level = 1'b0;

  pulse_stretch #(
    .N       (4),
    .ON_CNT  (4),
    .OFF_CNT (3),
    .PEND_W  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .clr_ovf   (clr_ovf),
    .level     (level),
    .busy      (busy),
    .pend_cnt  (pend_cnt),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
    if (level && !prev_level) rises++;
    prev_level = level;
  endtask

  task automatic to_cyc(input int k);
    while (cyc < k) adv();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    tick    = 1'b0;
    clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset      = 1'b0;
    cyc        = 0;
    rises      = 0;
    prev_level = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    clr_ovf = 1'b0;

    // Reset state
    do_reset();
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", dbg_state, IDLE);

    // Single tick at 10: high 11-14, low 15-17, idle from 18
    to_cyc(10); tick = 1'b1; adv(); tick = 1'b0;
    for (int k = 11; k <= 20; k++) begin
      to_cyc(k);
      chk("s1_level", level, (k >= 11 && k <= 14));
      chk("s1_busy", busy, (k <= 17));
      chk("s1_pend", pend_cnt, 0);
    end

    // Ticks at 10 and 12: second one queued, pulses 11-14 and 18-21
    do_reset();
    to_cyc(10); tick = 1'b1; adv(); tick = 1'b0;
    to_cyc(12); tick = 1'b1; adv(); tick = 1'b0;
    for (int k = 13; k <= 26; k++) begin
      to_cyc(k);
      chk("s2_level", level, ((k >= 11 && k <= 14) || (k >= 18 && k <= 21)));
      chk("s2_busy", busy, (k <= 24));
      chk("s2_pend", pend_cnt, (k <= 17) ? 1 : 0);
    end
    chk("s2_pulses", rises, 2);

    // Ticks 10..14: queue saturates, one tick dropped, four pulses total
    do_reset();
    to_cyc(10); tick = 1'b1;
    to_cyc(14);
    chk("s3_pend_sat", pend_cnt, 3);
    chk("s3_ovf_pre", ovf, 0);
    adv(); tick = 1'b0;
    chk("s3_ovf_set", ovf, 1);
    chk("s3_pend_hold", pend_cnt, 3);
    to_cyc(18);
    chk("s3_pend_18", pend_cnt, 2);
    chk("s3_level_18", level, 1);
    to_cyc(39);
    chk("s3_pulses", rises, 4);
    chk("s3_busy_39", busy, 0);
    chk("s3_ovf_sticky", ovf, 1);
    clr_ovf = 1'b1; adv(); adv(); clr_ovf = 1'b0;
    to_cyc(40); clr_ovf = 1'b1; adv(); clr_ovf = 1'b0;
    chk("s3_ovf_clr", ovf, 0);
    chk("s3_pulses_end", rises, 4);

    // Tick in the last GAP cycle goes straight back to ON
    do_reset();
    to_cyc(10); tick = 1'b1; adv(); tick = 1'b0;
    to_cyc(17);
    chk("s4_level_17", level, 0);
    chk("s4_busy_17", busy, 1);
    tick = 1'b1; adv(); tick = 1'b0;
    chk("s4_level_18", level, 1);
    chk("s4_state_18", dbg_state, ON);
    chk("s4_pend_18", pend_cnt, 0);
    to_cyc(21);
    chk("s4_level_21", level, 1);
    to_cyc(22);
    chk("s4_level_22", level, 0);
    chk("s4_pend_22", pend_cnt, 0);

    // Reset mid-pulse with one tick queued
    do_reset();
    to_cyc(10); tick = 1'b1;
    to_cyc(12); tick = 1'b0;
    chk("s5_pend_12", pend_cnt, 1);
    chk("s5_level_12", level, 1);
    reset = 1'b1; adv(); reset = 1'b0;
    chk("s5_level_13", level, 0);
    chk("s5_busy_13", busy, 0);
    chk("s5_pend_13", pend_cnt, 0);
    chk("s5_ovf_13", ovf, 0);
    chk("s5_state_13", dbg_state, IDLE);
    rises = 0;
    to_cyc(30);
    chk("s5_no_pulse", rises, 0);
    chk("s5_busy_30", busy, 0);

    // Saturating tick and clr_ovf together: set wins
    do_reset();
    to_cyc(10); tick = 1'b1;
    to_cyc(14);
    chk("s6_ovf_pre", ovf, 0);
    clr_ovf = 1'b1;
    adv(); tick = 1'b0; clr_ovf = 1'b0;
    chk("s6_ovf_set_wins", ovf, 1);
    to_cyc(16); clr_ovf = 1'b1; adv(); clr_ovf = 1'b0;
    chk("s6_ovf_clr", ovf, 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
